seg_scan_ctrl: RTL and testbench

Scan scheduler and frame-buffer controller for the board's 4-digit multiplexed 7-segment display. Owns the shared segment bus `HEX` and the digit enables `HEX_DIGIT`, time-slicing them across four digits with a dead-time guard between slots. Host logic loads digit values through a valid/ready write port into a shadow buffer. A commit request makes the shadow buffer visible atomically at the next frame boundary, so the display never tears.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_hex_decode.sv | 15 +
 rtl/seg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan controller.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low patterns indexed by nibble; bit 7 (dp) is off in every entry.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic       dp;
        logic [3:0] value;
    } digit_t;

    function automatic logic [7:0] seg_pattern(input logic [3:0] value, input logic dp);
        logic [7:0] seg;
        seg = SEG_TABLE[value];
        return {~dp, seg[6:0]};
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point to active-low segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] pattern
);

    // Table lookup with dp folded into bit 7.
    always_comb begin
        pattern = seg_pattern(value, dp);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler and double-buffered frame controller for a 4-digit 7-segment display.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [3:0] wr_value,
    input  logic       wr_dp,
    input  logic       commit,
    output logic       frame_tick,
    output logic [7:0] HEX,
    output logic [3:0] HEX_DIGIT
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);

    logic [CW-1:0] cnt_r;
    logic [1:0]    slot_r;
    slot_state_t   state_r;
    logic [7:0]    hex_r;
    logic [3:0]    hex_digit_r;
    logic          frame_tick_r;
    logic          pending_r;
    logic          wr_ready_r;
    digit_t [3:0]  shadow_r;
    digit_t [3:0]  active_r;
    digit_t [3:0]  shadow_next_s;
    digit_t        act_sel_s;
    logic [7:0]    pattern_s;
    logic [7:0]    drive_hex_s;
    logic          fb_s;
    logic          accept_s;

    assign fb_s       = (slot_r == 2'd3) && (cnt_r == CNT_MAX);
    assign accept_s   = wr_valid && wr_ready_r;
    assign act_sel_s  = active_r[slot_r];
    assign wr_ready   = wr_ready_r;
    assign frame_tick = frame_tick_r;
    assign HEX        = hex_r;
    assign HEX_DIGIT  = hex_digit_r;

    seg_hex_decode u_decode (
        .value   (act_sel_s.value),
        .dp      (act_sel_s.dp),
        .pattern (pattern_s)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [3:0] lead_zero_s;

    // lead_zero_s[k] is set when digit k and every digit above it are zero with dp off.
    always_comb begin
        lead_zero_s[3] = (active_r[3] == 5'd0);
        lead_zero_s[2] = lead_zero_s[3] && (active_r[2] == 5'd0);
        lead_zero_s[1] = lead_zero_s[2] && (active_r[1] == 5'd0);
        lead_zero_s[0] = 1'b0;
        if (lead_zero_s[slot_r]) begin
            drive_hex_s = SEG_BLANK;
        end else begin
            drive_hex_s = pattern_s;
        end
    end
`else
    // All digits decoded unconditionally.
    always_comb begin
        drive_hex_s = pattern_s;
    end
`endif

    // Shadow image after this cycle's accepted write, also the source of a commit copy.
    always_comb begin
        shadow_next_s = shadow_r;
        if (accept_s) begin
            shadow_next_s[wr_digit] = '{dp: wr_dp, value: wr_value};
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Slot counter: cnt wraps every SCAN_DIV cycles and advances the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            slot_r <= 2'd0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r  <= '0;
            slot_r <= slot_r + 2'd1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    // Shadow writes and frame-boundary publish; a pending commit blocks the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r   <= '0;
            active_r   <= '0;
            pending_r  <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            shadow_r <= shadow_next_s;
            if (fb_s && (pending_r || commit)) begin
                active_r   <= shadow_next_s;
                pending_r  <= 1'b0;
                wr_ready_r <= 1'b1;
            end else if (commit) begin
                pending_r  <= 1'b1;
                wr_ready_r <= 1'b0;
            end else begin
                pending_r  <= pending_r;
                wr_ready_r <= wr_ready_r;
            end
        end
    end

    // Slot FSM: segment bus and enables change together, only on BLANK/DRIVE edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BLANK;
            hex_r        <= SEG_BLANK;
            hex_digit_r  <= 4'hF;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= fb_s;
            case (state_r)
                ST_BLANK: begin
                    if (cnt_r == CNT_DEAD) begin
                        state_r     <= ST_DRIVE;
                        hex_r       <= drive_hex_s;
                        hex_digit_r <= ~(4'b0001 << slot_r);
                    end else begin
                        state_r <= ST_BLANK;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == '0) begin
                        state_r     <= ST_BLANK;
                        hex_r       <= SEG_BLANK;
                        hex_digit_r <= 4'hF;
                    end else begin
                        state_r <= ST_DRIVE;
                    end
                end
                default: begin
                    state_r     <= ST_BLANK;
                    hex_r       <= SEG_BLANK;
                    hex_digit_r <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-level reference model.
module tb_seg_scan_ctrl;

    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       commit = 1'b0;
    logic       wr_dp = 1'b0;
    logic [1:0] wr_digit = 2'd0;
    logic [3:0] wr_value = 4'd0;
    logic       wr_ready;
    logic       frame_tick;
    logic [7:0] HEX;
    logic [3:0] HEX_DIGIT;

    int checks = 0;
    int errors = 0;

    logic [7:0] dec_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int  sh_val [4];
    bit  sh_dp  [4];
    int  ac_val [4];
    bit  ac_dp  [4];
    bit  m_pend;
    int  n;

    seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_digit   (wr_digit),
        .wr_value   (wr_value),
        .wr_dp      (wr_dp),
        .commit     (commit),
        .frame_tick (frame_tick),
        .HEX        (HEX),
        .HEX_DIGIT  (HEX_DIGIT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_val[i] = 0; sh_dp[i] = 1'b0;
            ac_val[i] = 0; ac_dp[i] = 1'b0;
        end
        m_pend = 1'b0;
        n = 0;
    endtask

    function automatic logic [7:0] exp_pattern(input int s);
        logic [7:0] p;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        bit lz;
`endif
        p = dec_tbl[ac_val[s]];
        p[7] = ~ac_dp[s];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz = 1'b1;
        for (int j = s; j < 4; j++) begin
            if (ac_val[j] != 0 || ac_dp[j]) lz = 1'b0;
        end
        if (s != 0 && lz) p = 8'hFF;
`endif
        return p;
    endfunction

    // One clock: predict outputs from the time index, update the buffers, then compare.
    task automatic tick();
        int c, s;
        bit fb, acc;
        logic [7:0] eh;
        logic [3:0] ed;
        @(posedge clk);
        c  = n % SD;
        s  = (n / SD) % 4;
        fb = (c == SD - 1) && (s == 3);
        if (c < DC) begin
            eh = 8'hFF;
            ed = 4'hF;
        end else begin
            eh = exp_pattern(s);
            ed = ~(4'b0001 << s);
        end
        acc = wr_valid && !m_pend;
        if (acc) begin
            sh_val[wr_digit] = int'(wr_value);
            sh_dp[wr_digit]  = wr_dp;
        end
        if (fb && (m_pend || commit)) begin
            for (int i = 0; i < 4; i++) begin
                ac_val[i] = sh_val[i];
                ac_dp[i]  = sh_dp[i];
            end
            m_pend = 1'b0;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        n++;
        #1;
        chk("hex", 32'(HEX), 32'(eh));
        chk("hex_digit", 32'(HEX_DIGIT), 32'(ed));
        chk("frame_tick", 32'(frame_tick), 32'(fb));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
    endtask

    task automatic write_digit(input int d, input int v, input bit dp);
        wr_valid = 1'b1;
        wr_digit = 2'(d);
        wr_value = 4'(v);
        wr_dp    = dp;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex", 32'(HEX), 32'h0000_00FF);
        chk("rst_hex_digit", 32'(HEX_DIGIT), 32'h0000_000F);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0000_0001);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running scan over more than one frame.
        repeat (FRAME + 8) tick();

        // Load 4,3,2,1 (dp on digit 2) and publish.
        for (int d = 0; d < 4; d++) write_digit(d, 4 - d, d == 2);
        do_commit();

        // Backpressure while pending, including a redundant second commit.
        for (int i = 0; i < 80; i++) begin
            wr_valid = 1'b1;
            wr_digit = 2'($urandom_range(3, 0));
            wr_value = 4'($urandom_range(15, 0));
            wr_dp    = 1'($urandom_range(1, 0));
            commit   = (i == 10);
            tick();
        end
        wr_valid = 1'b0;
        commit   = 1'b0;
        repeat (2 * FRAME) tick();

        // Write and commit together on the frame-boundary cycle.
        for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) tick();
        wr_valid = 1'b1;
        wr_digit = 2'd1;
        wr_value = 4'hA;
        wr_dp    = 1'b0;
        commit   = 1'b1;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
        repeat (FRAME + 4) tick();

        // Value 0005 exercises leading-zero handling.
        for (int d = 0; d < 4; d++) write_digit(d, (d == 0) ? 5 : 0, 1'b0);
        do_commit();
        repeat (2 * FRAME + 4) tick();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom_range(2, 0) == 0);
            wr_digit = 2'($urandom_range(3, 0));
            wr_value = 4'($urandom_range(15, 0));
            wr_dp    = ($urandom_range(3, 0) == 0);
            commit   = ($urandom_range(49, 0) == 0);
            tick();
        end
        wr_valid = 1'b0;
        commit   = 1'b0;

        // Asynchronous reset in mid-frame with a commit pending.
        do_commit();
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hex", 32'(HEX), 32'h0000_00FF);
        chk("mid_rst_hex_digit", 32'(HEX_DIGIT), 32'h0000_000F);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'h0000_0001);
        chk("mid_rst_frame_tick", 32'(frame_tick), 32'h0000_0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
